// File: rtl/ir_carrier_divider_if.sv
// Config, control and status bundle for the multi-channel IR carrier divider.
interface ir_carrier_divider_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned BURST_W  = 8
);
    logic [CHANNELS-1:0] cfg_we;
    logic [DIV_W-1:0]    cfg_div;
    logic [DIV_W-1:0]    cfg_high;
    logic [BURST_W-1:0]  cfg_burst;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] stop;
    logic [CHANNELS-1:0] carrier_out;
    logic [CHANNELS-1:0] period_tick;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;

    modport master (
        output cfg_we, cfg_div, cfg_high, cfg_burst, start, stop,
        input  carrier_out, period_tick, busy, done
    );

    modport slave (
        input  cfg_we, cfg_div, cfg_high, cfg_burst, start, stop,
        output carrier_out, period_tick, busy, done
    );
endinterface

// File: rtl/ir_carrier_divider.sv
// Multi-channel programmable carrier divider: per-channel period/high-time
// generator with shadowed config, continuous or burst operation.
module ir_carrier_divider #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned BURST_W  = 8
) (
    input logic                clk,
    input logic                reset,
    ir_carrier_divider_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

    logic [CHANNELS-1:0] carrier_v;
    logic [CHANNELS-1:0] tick_v;
    logic [CHANNELS-1:0] busy_v;
    logic [CHANNELS-1:0] done_v;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_e             state_q, state_d;
        logic [DIV_W-1:0]   cnt_q, cnt_d;
        logic [BURST_W-1:0] per_q, per_d;
        logic [DIV_W-1:0]   div_q, div_d, high_q, high_d;
        logic [BURST_W-1:0] burst_q, burst_d;
        logic [DIV_W-1:0]   sdiv_q, sdiv_d, shigh_q, shigh_d;
        logic [BURST_W-1:0] sburst_q, sburst_d;
        logic               carrier_q, carrier_d;
        logic               tick_q, tick_d;
        logic               busy_q, busy_d;
        logic               done_q, done_d;
        logic               boundary;
        logic               load;
        logic               running;

        // Shadow config capture; a write in a boundary cycle is visible to that boundary's load.
        always_comb begin
            sdiv_d   = sdiv_q;
            shigh_d  = shigh_q;
            sburst_d = sburst_q;
            if (bus.cfg_we[c]) begin
                sdiv_d   = (bus.cfg_div < DIV_W'(2)) ? DIV_W'(2) : bus.cfg_div;
                shigh_d  = bus.cfg_high;
                sburst_d = bus.cfg_burst;
            end
        end

        // Channel FSM, period/burst counting and registered-output next values.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            per_d    = per_q;
            div_d    = div_q;
            high_d   = high_q;
            burst_d  = burst_q;
            done_d   = 1'b0;
            load     = 1'b0;
            boundary = (cnt_q == div_q - DIV_W'(1));
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    per_d = '0;
                    load  = 1'b1;
                    // stop wins over a simultaneous start
                    if (bus.start[c] && !bus.stop[c]) begin
                        state_d = StRun;
                    end
                end
                StRun, StStopping: begin
                    if (boundary) begin
                        cnt_d = '0;
                        per_d = per_q + BURST_W'(1);
                        load  = 1'b1;
                        if (state_q == StStopping || bus.stop[c] ||
                            (burst_q != '0 && per_d == burst_q)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                        if (state_q == StRun && bus.stop[c]) begin
                            state_d = StStopping;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
            if (load) begin
                div_d   = sdiv_d;
                high_d  = shigh_d;
                burst_d = sburst_d;
            end
            // Outputs registered so they line up with the cnt value they describe.
            running   = (state_d != StIdle);
            carrier_d = running && (cnt_d < high_d);
            tick_d    = running && (cnt_d == div_d - DIV_W'(1));
            busy_d    = running;
        end

        // State and output registers, asynchronous active-high reset.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                per_q     <= '0;
                div_q     <= DIV_W'(2);
                high_q    <= DIV_W'(1);
                burst_q   <= '0;
                sdiv_q    <= DIV_W'(2);
                shigh_q   <= DIV_W'(1);
                sburst_q  <= '0;
                carrier_q <= 1'b0;
                tick_q    <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                per_q     <= per_d;
                div_q     <= div_d;
                high_q    <= high_d;
                burst_q   <= burst_d;
                sdiv_q    <= sdiv_d;
                shigh_q   <= shigh_d;
                sburst_q  <= sburst_d;
                carrier_q <= carrier_d;
                tick_q    <= tick_d;
                busy_q    <= busy_d;
                done_q    <= done_d;
            end
        end

        assign carrier_v[c] = carrier_q;
        assign tick_v[c]    = tick_q;
        assign busy_v[c]    = busy_q;
        assign done_v[c]    = done_q;
    end

    assign bus.carrier_out = carrier_v;
    assign bus.period_tick = tick_v;
    assign bus.busy        = busy_v;
    assign bus.done        = done_v;
endmodule

// File: tb/tb_ir_carrier_divider.sv
// Self-checking bench for ir_carrier_divider: directed scenarios plus random
// traffic compared against a period-level behavioural model.
module tb_ir_carrier_divider;
    localparam int CH = 2;
    localparam int DW = 16;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ir_carrier_divider_if #(.CHANNELS(CH), .DIV_W(DW), .BURST_W(BW)) bus ();

    ir_carrier_divider #(.CHANNELS(CH), .DIV_W(DW), .BURST_W(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: shadow/active config, whether a channel is on, position inside the
    // current period and number of completed periods.
    int m_sdiv [CH], m_shigh [CH], m_sburst [CH];
    int m_div [CH], m_high [CH], m_burst [CH];
    int m_pos [CH], m_nper [CH];
    bit m_on [CH], m_stopping [CH], m_done [CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_sdiv[c] = 2; m_shigh[c] = 1; m_sburst[c] = 0;
            m_div[c] = 2;  m_high[c] = 1;  m_burst[c] = 0;
            m_pos[c] = 0;  m_nper[c] = 0;
            m_on[c] = 0;   m_stopping[c] = 0; m_done[c] = 0;
        end
    endfunction

    function automatic void take_shadow(input int c);
        m_div[c]   = m_sdiv[c];
        m_high[c]  = m_shigh[c];
        m_burst[c] = m_sburst[c];
    endfunction

    // Advance the model by one clock using the inputs present at that edge.
    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            bit finished;
            if (bus.cfg_we[c]) begin
                m_sdiv[c]   = (int'(bus.cfg_div) < 2) ? 2 : int'(bus.cfg_div);
                m_shigh[c]  = int'(bus.cfg_high);
                m_sburst[c] = int'(bus.cfg_burst);
            end
            m_done[c] = 0;
            if (!m_on[c]) begin
                take_shadow(c);
                m_pos[c]  = 0;
                m_nper[c] = 0;
                if (bus.start[c] && !bus.stop[c]) begin
                    m_on[c]       = 1;
                    m_stopping[c] = 0;
                end
            end else if (m_pos[c] == m_div[c] - 1) begin
                m_nper[c]++;
                finished = m_stopping[c] || bus.stop[c] ||
                           (m_burst[c] != 0 && m_nper[c] == m_burst[c]);
                take_shadow(c);
                m_pos[c] = 0;
                if (finished) begin
                    m_on[c]   = 0;
                    m_done[c] = 1;
                end
            end else begin
                m_pos[c]++;
                if (bus.stop[c]) m_stopping[c] = 1;
            end
        end
    endfunction

    task automatic check_outputs();
        for (int c = 0; c < CH; c++) begin
            check($sformatf("carrier%0d", c), bus.carrier_out[c], m_on[c] && (m_pos[c] < m_high[c]));
            check($sformatf("tick%0d", c), bus.period_tick[c], m_on[c] && (m_pos[c] == m_div[c] - 1));
            check($sformatf("busy%0d", c), bus.busy[c], m_on[c]);
            check($sformatf("done%0d", c), bus.done[c], m_done[c]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic write_cfg(input int c, input int d, input int h, input int b);
        bus.cfg_we    = '0;
        bus.cfg_we[c] = 1'b1;
        bus.cfg_div   = DW'(d);
        bus.cfg_high  = DW'(h);
        bus.cfg_burst = BW'(b);
        cycle();
        bus.cfg_we = '0;
    endtask

    task automatic pulse_start(input int c);
        bus.start[c] = 1'b1;
        cycle();
        bus.start[c] = 1'b0;
    endtask

    task automatic pulse_stop(input int c);
        bus.stop[c] = 1'b1;
        cycle();
        bus.stop[c] = 1'b0;
    endtask

    task automatic wait_idle(input int c, input int budget);
        for (int i = 0; i < budget && bus.busy[c]; i++) cycle();
        check("idle_timeout", bus.busy[c], 1'b0);
    endtask

    initial begin
        logic [9:0] pat;
        int hi, rises, bz, dn, didx, n;
        bit prev;

        bus.cfg_we = '0; bus.cfg_div = '0; bus.cfg_high = '0; bus.cfg_burst = '0;
        bus.start = '0;  bus.stop = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_carrier", bus.carrier_out, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        check_outputs();

        // div=4 high=2 continuous: 1,1,0,0 repeating, one tick per 4 cycles
        write_cfg(0, 4, 2, 0);
        pulse_start(0);
        pat = '0; n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cycle();
            pat[i] = bus.carrier_out[0];
            if (bus.period_tick[0]) n++;
        end
        check("div4_pattern", pat, 10'b0000110011);
        check("div4_ticks", n, 2);
        pulse_stop(0);
        wait_idle(0, 20);

        // div=38 high=13 burst=3
        write_cfg(0, 38, 13, 3);
        pulse_start(0);
        hi = 0; rises = 0; bz = 0; dn = 0; didx = -1; prev = 0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) cycle();
            if (bus.carrier_out[0]) hi++;
            if (bus.carrier_out[0] && !prev) rises++;
            prev = bus.carrier_out[0];
            if (bus.busy[0]) bz++;
            if (bus.done[0]) begin
                dn++;
                if (didx < 0) didx = i;
            end
            if (didx >= 0 && i > didx + 2) break;
        end
        check("burst_high_cycles", hi, 39);
        check("burst_pulses", rises, 3);
        check("burst_busy_cycles", bz, 114);
        check("burst_done_count", dn, 1);
        check("burst_done_index", didx, 114);

        // mid-period reconfiguration takes effect only at the next period
        write_cfg(0, 4, 2, 0);
        pulse_start(0);
        pat = '0;
        pat[0] = bus.carrier_out[0];
        for (int i = 1; i < 10; i++) begin
            if (i == 2) begin
                bus.cfg_we = 2'b01; bus.cfg_div = DW'(6); bus.cfg_high = DW'(3);
                bus.cfg_burst = '0;
            end
            cycle();
            bus.cfg_we = '0;
            pat[i] = bus.carrier_out[0];
        end
        check("reconfig_pattern", pat, 10'b0001110011);
        pulse_stop(0);
        wait_idle(0, 20);

        // div clamp: 1 behaves as 2
        write_cfg(0, 1, 1, 0);
        pulse_start(0);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycle();
            pat[i] = bus.carrier_out[0];
        end
        check("clamp_pattern", pat, 10'b0000000101);
        pulse_stop(0);
        wait_idle(0, 20);

        // high=0 gives constant 0
        write_cfg(0, 5, 0, 0);
        pulse_start(0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cycle();
            if (bus.carrier_out[0]) hi++;
        end
        check("high0_count", hi, 0);
        pulse_stop(0);
        wait_idle(0, 20);

        // high>=div gives constant 1
        write_cfg(0, 8, 10, 0);
        pulse_start(0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cycle();
            if (bus.carrier_out[0]) hi++;
        end
        check("highbig_count", hi, 10);
        pulse_stop(0);
        wait_idle(0, 20);

        // stop at cnt=1 of div=8: period completes, then done
        write_cfg(0, 8, 4, 0);
        pulse_start(0);
        cycle();
        pulse_stop(0);
        n = 0;
        while (!bus.done[0] && n < 20) begin
            cycle();
            n++;
        end
        check("stop_cycles", n, 6);
        check("stop_busy", bus.busy[0], 1'b0);

        // start+stop together in IDLE stays IDLE
        bus.start[0] = 1'b1; bus.stop[0] = 1'b1;
        cycle();
        bus.start[0] = 1'b0; bus.stop[0] = 1'b0;
        check("startstop_busy", bus.busy[0], 1'b0);
        cycle();

        // two channels, reset mid-burst, then restart
        write_cfg(0, 5, 2, 4);
        write_cfg(1, 7, 6, 0);
        bus.start = 2'b11;
        cycle();
        bus.start = '0;
        repeat (8) cycle();
        #2 reset = 1'b1;
        #1;
        check("arst_carrier", bus.carrier_out, 0);
        check("arst_tick", bus.period_tick, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cycle();
        write_cfg(0, 5, 2, 4);
        write_cfg(1, 7, 6, 0);
        bus.start = 2'b11;
        cycle();
        bus.start = '0;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (bus.done[0]) dn++;
        end
        check("restart_done0", dn, 1);
        check("restart_busy1", bus.busy[1], 1'b1);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bus.cfg_we = '0;
            if ($urandom_range(0, 9) == 0) bus.cfg_we[$urandom_range(0, CH - 1)] = 1'b1;
            bus.cfg_div   = DW'($urandom_range(0, 12));
            bus.cfg_high  = DW'($urandom_range(0, 14));
            bus.cfg_burst = BW'($urandom_range(0, 4));
            for (int c = 0; c < CH; c++) begin
                bus.start[c] = ($urandom_range(0, 7) == 0);
                bus.stop[c]  = ($urandom_range(0, 19) == 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
